alu_issue_ctrl: RTL

- Issue/control unit that drives the 8-bit ALU's operand side and consumes its result side.
- Accepts one 9-bit instruction at a time over a valid/ready handshake and decodes it.
- Reads two operands from a local 8x8 register file, drives `ALU_OP`/`ALU_R1`/`ALU_R2`, then writes `ALU_OUT` back to the register file.
- Holds the sticky overflow/zero flags that the ALU only reports combinationally.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/reg_file.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU issue/control slice: opcodes, controller
// states, instruction field positions and the datapath width.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  // Instruction fields: [8:6] opcode, [5:3] rd, [2:0] rs/imm3
  localparam int unsigned OPC_MSB = 8;
  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned RS_MSB  = 2;
  localparam int unsigned RS_LSB  = 0;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_XOR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_LDI  = 3'b101,
    OP_MOV  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  // Opcodes the external ALU actually computes
  function automatic logic is_alu_op(input op_e op);
    return (op == OP_AND) || (op == OP_XOR) || (op == OP_SHL) ||
           (op == OP_SHR) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: synchronous reset to zero, one synchronous write port,
// two combinational operand read ports and one combinational debug port.
module reg_file #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1,
  output logic [DATA_W-1:0]           rdata1,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2,
  output logic [DATA_W-1:0]           rdata2,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: reset clears every entry, otherwise a single write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/control unit for the 8-bit ALU: accepts one instruction at a time,
// drives the ALU operands for one cycle, writes the result back and keeps
// sticky carry/zero flags from the last ADD.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned INSTR_W  = 9
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [INSTR_W-1:0]          INSTR,
  input  logic                        INSTR_VALID,
  output logic                        INSTR_READY,
  output logic [2:0]                  ALU_OP,
  output logic [DATA_W-1:0]           ALU_R1,
  output logic [DATA_W-1:0]           ALU_R2,
  input  logic [DATA_W-1:0]           ALU_OUT,
  input  logic [1:0]                  ALU_OVERFLOW,
  input  logic                        ALU_ZF,
  output logic                        DONE,
  output logic                        HALTED,
  output logic                        CARRY_FLAG,
  output logic                        ZERO_FLAG,
  input  logic [$clog2(NUM_REGS)-1:0] DBG_ADDR,
  output logic [DATA_W-1:0]           DBG_DATA
);

  import cpu_pkg::*;

  state_e              state;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   res;
  op_e                 opcode;
  logic [2:0]          rd_addr;
  logic [2:0]          rs_addr;
  logic [DATA_W-1:0]   rs_data;
  logic [DATA_W-1:0]   rd_data;
  logic                unused_signed_ovf;

  assign opcode  = op_e'(ir[OPC_MSB:OPC_LSB]);
  assign rd_addr = ir[RD_MSB:RD_LSB];
  assign rs_addr = ir[RS_MSB:RS_LSB];

  // Only the carry bit of the ALU overflow pair feeds a flag
  assign unused_signed_ovf = ALU_OVERFLOW[1];

  reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk      (CLK),
    .rst      (RESET),
    .we       (state == S_WB),
    .waddr    (rd_addr),
    .wdata    (res),
    .raddr1   (rs_addr),
    .rdata1   (rs_data),
    .raddr2   (rd_addr),
    .rdata2   (rd_data),
    .dbg_addr (DBG_ADDR),
    .dbg_data (DBG_DATA)
  );

  // ALU operand side: live only in EXEC, zero operands otherwise
  always_comb begin
    ALU_OP = 3'b111;
    ALU_R1 = '0;
    ALU_R2 = '0;
    if (state == S_EXEC) begin
      ALU_OP = is_alu_op(opcode) ? opcode : 3'b111;
      ALU_R1 = rs_data;
      ALU_R2 = rd_data;
    end
  end

  // Controller FSM with registered handshake, status and flag outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      ir          <= '0;
      res         <= '0;
      INSTR_READY <= 1'b1;
      DONE        <= 1'b0;
      HALTED      <= 1'b0;
      CARRY_FLAG  <= 1'b0;
      ZERO_FLAG   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (INSTR_VALID && INSTR_READY) begin
            ir          <= INSTR;
            INSTR_READY <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_LDI:  res <= DATA_W'(ir[RS_MSB:RS_LSB]);
            OP_MOV:  res <= rs_data;
            default: res <= ALU_OUT;
          endcase
          if (opcode == OP_ADD) begin
            CARRY_FLAG <= ALU_OVERFLOW[0];
            ZERO_FLAG  <= ALU_ZF;
          end
          // DONE is set here so that it is visible during WB / HALT entry
          DONE <= 1'b1;
          if (opcode == OP_HALT) begin
            HALTED <= 1'b1;
            state  <= S_HALT;
          end else begin
            state  <= S_WB;
          end
        end
        S_WB: begin
          INSTR_READY <= 1'b1;
          state       <= S_IDLE;
        end
        S_HALT: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule
